cache_controller: RTL and testbench
===================================

# cache_controller

Direct-mapped, write-through, no-write-allocate cache controller that sits between the CPU-side request port and the `ram` block. It is the initiator on the `ram` address/data/write/out interface: it issues reads on misses, issues a memory write on every store, and answers read hits locally from its line store. It also keeps saturating hit and miss counters for the cache test benches.

## Interface

Parameters:
- `LINES`, 64: number of cache lines; each line holds one 32-bit word. Must be a power of two.
- `MEM_WORDS`, 4096: `ram` depth in words. Must be a power of two.
- `MEM_LATENCY`, 2: cycles the controller holds `mem_address` before sampling `mem_out`. Must be ≥ 1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req`  in  1  CPU request valid; sampled only when `ready`=1.
- `we`  in  1  1 = store, 0 = load.
- `addr`  in  32  CPU word address; reduced modulo `MEM_WORDS`.
- `wdata`  in  32  store data.
- `ready`  out  1  controller can accept a request this cycle.
- `rvalid`  out  1  one-cycle pulse; `rdata` is valid for a load.
- `rdata`  out  32  load result.
- `hit`  out  1  qualifies `rvalid`: 1 = served from cache.
- `hit_count`  out  16  saturating count of load hits.
- `miss_count`  out  16  saturating count of load misses.
- `mem_address`  out  32  to `ram.address`.
- `mem_data`  out  32  to `ram.data`.
- `mem_write`  out  1  to `ram.write`.
- `mem_out`  in  32  from `ram.out`.

## Operation

- Address decomposition:
  - Effective address `ea = addr mod MEM_WORDS`; upper bits are ignored.
  - Index = `ea[log2(LINES)-1:0]`.
  - Tag = remaining upper bits of `ea`. With the defaults this is 6 index bits and 6 tag bits.
- Line store: one valid bit, tag and data word per line. All valid bits are cleared by reset.
- FSM states:
  - **IDLE**: `ready`=1. A load that hits returns data and stays in IDLE. A load that misses goes to **MEM_RD**. A store goes to **MEM_WR**.
  - **MEM_RD**: drives `mem_address`=`ea` and `mem_write`=0 for `MEM_LATENCY` cycles. On the last edge it samples `mem_out`, writes valid/tag/data into the line, then goes to **RESP**.
  - **RESP**: pulses `rvalid` with `hit`=0, `rdata` = fetched word, `ready`=1 → IDLE. A `req` in this cycle is accepted.
  - **MEM_WR**: drives `mem_address`=`ea`, `mem_data`=`wdata` and `mem_write`=1 for `MEM_LATENCY` cycles, then → IDLE.
    - If the store hit, the line data is updated on entry.
    - If the store missed, line contents are unchanged (no allocate).
- Stores produce no `rvalid` and do not change either counter.
- Counters saturate at 16'hFFFF and never wrap.
- Outside MEM_RD/MEM_WR: `mem_write`=0; `mem_address`/`mem_data` hold their last values.

## Timing

- Cycle 0 is the edge where `req`&`ready` is sampled.
- Load hit: `rvalid`=1 and `hit`=1 in cycle 1. `ready` stays 1, so back-to-back hits run at one request per cycle.
- Load miss: `ready`=0 in cycles 1..`MEM_LATENCY`. `rvalid`=1, `hit`=0 and `ready`=1 in cycle `MEM_LATENCY`+1. With defaults, the result arrives in cycle 3.
- Store: `mem_write`=1 and `ready`=0 in cycles 1..`MEM_LATENCY`. `ready`=1 in cycle `MEM_LATENCY`+1.
- The CPU must hold `req`/`we`/`addr`/`wdata` stable until it sees `ready`=1. Requests with `ready`=0 are ignored, not queued.
- Load to a line that is being written in the same cycle: the lookup sees the pre-write contents. This cannot occur because the FSM serialises requests.
- Reset values:
  - `ready`=1 (state IDLE).
  - `rvalid`, `hit`, `mem_write` = 0.
  - `rdata`, `mem_address`, `mem_data`, `hit_count`, `miss_count` = 0.
  - `req` is ignored in any cycle with `rst_n`=0.
- Reset mid-operation: the next edge returns to IDLE, drops `mem_write`, clears all valid bits and suppresses any pending `rvalid`.

## Structure

- Package `cache_pkg`: FSM state encoding (IDLE, MEM_RD, RESP, MEM_WR), `INDEX_W`/`TAG_W` derivation helpers, and the counter width constant 16.
- Sub-module `cache_line_store`:
  - Holds the valid/tag/data arrays.
  - Combinational lookup returns hit and data.
  - One synchronous write port.
  - Bulk clear of valid bits on reset.
- The FSM, address decomposition and counters live in `cache_controller`.

## Test plan

- Store 14528 to addr 0 → `mem_write`=1, `mem_address`=0, `mem_data`=14528 in cycles 1–2; `ready`=1 in cycle 3; no `rvalid`.
- Load addr 0, cold → `rvalid`, `hit`=0, `rdata`=14528 in cycle 3; `miss_count`=1. Reload addr 0 → `rvalid`, `hit`=1, `rdata`=14528 in cycle 1; `hit_count`=1.
- Store 526421 to addr 2816867292 (ea 3036, index 28, tag 47) → `mem_address`=2816867292 mod 4096 = 3036. Load it → miss, then 526421. Load addr 28 (index 28, tag 0) → conflict miss; the line is replaced.
- Store 25369366 to 1001425 (ea 2001) after loading 1001425 into the cache → the line is updated. The following load hits in cycle 1 with `rdata` 25369366.
- Assert `rst_n`=0 in cycle 1 of a miss → next cycle `ready`=1, `mem_write`=0, no `rvalid`. A following load of the same address misses (valid bits cleared).
- Drive 65537 load hits → `hit_count` saturates at 65535.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the direct-mapped write-through cache controller.
package cache_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MEM_RD,
      ST_RESP,
      ST_MEM_WR
   } state_e;

   function automatic int index_w(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int tag_w(input int mem_words, input int lines);
      return $clog2(mem_words) - $clog2(lines);
   endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays: combinational lookup, one synchronous write port, valid bits cleared on reset.
// Zero-latency lookup; the write port is never stalled.
module cache_line_store #(
   parameter int INDEX_W = 6,
   parameter int TAG_W   = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INDEX_W-1:0] lk_idx_i,
   input  logic [TAG_W-1:0]   lk_tag_i,
   output logic               lk_hit_o,
   output logic [31:0]        lk_data_o,
   input  logic               wr_en_i,
   input  logic [INDEX_W-1:0] wr_idx_i,
   input  logic [TAG_W-1:0]   wr_tag_i,
   input  logic [31:0]        wr_data_i
);

   localparam int LINES = 1 << INDEX_W;

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [31:0]      data_q [LINES];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   // Tag and data need no reset: they are only trusted behind a valid bit.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign lk_hit_o  = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
   assign lk_data_o = data_q[lk_idx_i];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-through no-write-allocate cache: hits answer in 1 cycle, misses in MEM_LATENCY+1.
// ready drops while a memory read or write is in flight; requests seen with ready=0 are ignored.
module cache_controller
   import cache_pkg::*;
#(
   parameter int LINES       = 64,
   parameter int MEM_WORDS   = 4096,
   parameter int MEM_LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req,
   input  logic             we,
   input  logic [31:0]      addr,
   input  logic [31:0]      wdata,
   output logic             ready,
   output logic             rvalid,
   output logic [31:0]      rdata,
   output logic             hit,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count,
   output logic [31:0]      mem_address,
   output logic [31:0]      mem_data,
   output logic             mem_write,
   input  logic [31:0]      mem_out
);

   localparam int IDX_W = index_w(LINES);
   localparam int TAG_W = tag_w(MEM_WORDS, LINES);
   localparam int EA_W  = IDX_W + TAG_W;
   localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);

   state_e           state_q, state_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic [31:0]      mem_address_q, mem_address_d;
   logic [31:0]      mem_data_q, mem_data_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             rvalid_q, rvalid_d;
   logic             hit_q, hit_d;
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

   logic [EA_W-1:0]  ea;
   logic             lk_hit;
   logic [31:0]      lk_data;
   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [TAG_W-1:0] wr_tag;
   logic [31:0]      wr_data;
   logic             unused_addr_bits;

   assign ea               = addr[EA_W-1:0];
   assign unused_addr_bits = ^addr[31:EA_W];

   cache_line_store #(
      .INDEX_W (IDX_W),
      .TAG_W   (TAG_W)
   ) u_lines (
      .clk       (clk),
      .rst_n     (rst_n),
      .lk_idx_i  (ea[IDX_W-1:0]),
      .lk_tag_i  (ea[EA_W-1:IDX_W]),
      .lk_hit_o  (lk_hit),
      .lk_data_o (lk_data),
      .wr_en_i   (wr_en),
      .wr_idx_i  (wr_idx),
      .wr_tag_i  (wr_tag),
      .wr_data_i (wr_data)
   );

   always_comb begin
      state_d       = state_q;
      lat_d         = lat_q;
      mem_address_d = mem_address_q;
      mem_data_d    = mem_data_q;
      rdata_d       = rdata_q;
      rvalid_d      = 1'b0;
      hit_d         = 1'b0;
      hit_cnt_d     = hit_cnt_q;
      miss_cnt_d    = miss_cnt_q;
      wr_en         = 1'b0;
      wr_idx        = ea[IDX_W-1:0];
      wr_tag        = ea[EA_W-1:IDX_W];
      wr_data       = wdata;

      case (state_q)
         ST_IDLE, ST_RESP: begin
            state_d = ST_IDLE;
            if (req) begin
               if (we) begin
                  // Write-through: a store hit refreshes the line, a store miss leaves it alone.
                  wr_en         = lk_hit;
                  mem_address_d = 32'(ea);
                  mem_data_d    = wdata;
                  lat_d         = LAT_LAST;
                  state_d       = ST_MEM_WR;
               end else if (lk_hit) begin
                  rvalid_d = 1'b1;
                  hit_d    = 1'b1;
                  rdata_d  = lk_data;
                  if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
               end else begin
                  mem_address_d = 32'(ea);
                  lat_d         = LAT_LAST;
                  state_d       = ST_MEM_RD;
                  if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
               end
            end
         end
         ST_MEM_RD: begin
            if (lat_q == '0) begin
               wr_en    = 1'b1;
               wr_idx   = mem_address_q[IDX_W-1:0];
               wr_tag   = mem_address_q[EA_W-1:IDX_W];
               wr_data  = mem_out;
               rdata_d  = mem_out;
               rvalid_d = 1'b1;
               state_d  = ST_RESP;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         ST_MEM_WR: begin
            if (lat_q == '0) state_d = ST_IDLE;
            else             lat_d   = lat_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         lat_q         <= '0;
         mem_address_q <= '0;
         mem_data_q    <= '0;
         rdata_q       <= '0;
         rvalid_q      <= 1'b0;
         hit_q         <= 1'b0;
         hit_cnt_q     <= '0;
         miss_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         lat_q         <= lat_d;
         mem_address_q <= mem_address_d;
         mem_data_q    <= mem_data_d;
         rdata_q       <= rdata_d;
         rvalid_q      <= rvalid_d;
         hit_q         <= hit_d;
         hit_cnt_q     <= hit_cnt_d;
         miss_cnt_q    <= miss_cnt_d;
      end
   end

   assign ready       = (state_q == ST_IDLE) || (state_q == ST_RESP);
   assign mem_write   = (state_q == ST_MEM_WR);
   assign rvalid      = rvalid_q;
   assign rdata       = rdata_q;
   assign hit         = hit_q;
   assign hit_count   = hit_cnt_q;
   assign miss_count  = miss_cnt_q;
   assign mem_address = mem_address_q;
   assign mem_data    = mem_data_q;

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed vector table, reset/saturation sequences, random ops vs a reference model.
module tb_cache_controller;

   localparam int LINES     = 64;
   localparam int MEM_WORDS = 4096;
   localparam int MEM_LAT   = 2;

   logic        clk = 1'b0;
   logic        rst_n, req, we;
   logic [31:0] addr, wdata;
   logic        ready, rvalid, hit, mem_write;
   logic [31:0] rdata, mem_address, mem_data, mem_out;
   logic [15:0] hit_count, miss_count;

   int n_vec  = 0;
   int n_miss = 0;

   // Memory seen by the DUT (registered read port) and the bench's own shadow of it.
   logic [31:0] ram [MEM_WORDS];
   logic [31:0] ref_mem [MEM_WORDS];
   bit          m_valid [LINES];
   int          m_tag [LINES];
   int          m_hits, m_misses;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          exp_hit;
      logic [31:0] exp_data;
   } vec_t;
   vec_t vecs [10];

   always #5 clk = ~clk;

   cache_controller #(.LINES(LINES), .MEM_WORDS(MEM_WORDS), .MEM_LATENCY(MEM_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ready(ready), .rvalid(rvalid), .rdata(rdata), .hit(hit),
      .hit_count(hit_count), .miss_count(miss_count),
      .mem_address(mem_address), .mem_data(mem_data), .mem_write(mem_write), .mem_out(mem_out)
   );

   always @(posedge clk) begin
      mem_out <= ram[mem_address % MEM_WORDS];
      if (mem_write) ram[mem_address % MEM_WORDS] <= mem_data;
   end

   function automatic logic [31:0] pat(input int i);
      return i * 32'h0100_0193 + 32'h1234_5678;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < LINES; i++) m_valid[i] = 0;
      m_hits   = 0;
      m_misses = 0;
   endtask

   task automatic model_load(input logic [31:0] a, output bit eh, output logic [31:0] ed);
      int e, idx, tg;
      e   = int'(a % MEM_WORDS);
      idx = e % LINES;
      tg  = e / LINES;
      eh  = m_valid[idx] && (m_tag[idx] == tg);
      ed  = ref_mem[e];
      if (eh) m_hits   = (m_hits   < 65535) ? m_hits + 1   : 65535;
      else    m_misses = (m_misses < 65535) ? m_misses + 1 : 65535;
      m_valid[idx] = 1;
      m_tag[idx]   = tg;
   endtask

   task automatic model_store(input logic [31:0] a, input logic [31:0] d);
      ref_mem[a % MEM_WORDS] = d;
   endtask

   task automatic do_load(input logic [31:0] a, input bit eh, input logic [31:0] ed, input string nm);
      int c;
      bit got;
      req = 1'b1; we = 1'b0; addr = a; wdata = $urandom;
      @(posedge clk); #1 req = 1'b0;
      got = 0; c = 0;
      while (!got && c < 20) begin
         @(negedge clk);
         c++;
         if (rvalid) got = 1;
      end
      check({nm, " rvalid seen"}, 32'(got), 32'd1);
      if (got) begin
         check({nm, " latency"}, 32'(c), eh ? 32'd1 : 32'(MEM_LAT + 1));
         check({nm, " hit"}, 32'(hit), 32'(eh));
         check({nm, " rdata"}, rdata, ed);
         check({nm, " ready"}, 32'(ready), 32'd1);
         check({nm, " hit_count"}, 32'(hit_count), 32'(m_hits));
         check({nm, " miss_count"}, 32'(miss_count), 32'(m_misses));
      end
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input string nm);
      int bad;
      req = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(posedge clk); #1 req = 1'b0;
      bad = 0;
      for (int c = 1; c <= MEM_LAT; c++) begin
         @(negedge clk);
         if (!(mem_write === 1'b1 && mem_address === 32'(a % MEM_WORDS) && mem_data === d
               && ready === 1'b0 && rvalid === 1'b0)) bad++;
      end
      check({nm, " write phase cycles wrong"}, 32'(bad), 32'd0);
      @(negedge clk);
      check({nm, " ready after write"}, 32'(ready), 32'd1);
      check({nm, " mem_write after"}, 32'(mem_write), 32'd0);
      check({nm, " no rvalid"}, 32'(rvalid), 32'd0);
   endtask

   task automatic check_reset_state(input string nm);
      check({nm, " ready"}, 32'(ready), 32'd1);
      check({nm, " rvalid"}, 32'(rvalid), 32'd0);
      check({nm, " mem_write"}, 32'(mem_write), 32'd0);
      check({nm, " hit"}, 32'(hit), 32'd0);
      check({nm, " rdata"}, rdata, 32'd0);
      check({nm, " mem_address"}, mem_address, 32'd0);
      check({nm, " mem_data"}, mem_data, 32'd0);
      check({nm, " counts"}, {hit_count, miss_count}, 32'd0);
   endtask

   initial begin
      bit          eh;
      logic [31:0] ed;
      int          errs, seen;

      for (int i = 0; i < MEM_WORDS; i++) begin
         ram[i]     = pat(i);
         ref_mem[i] = pat(i);
      end
      model_reset();

      vecs[0] = '{1, 32'd0,          32'd14528,    0, 32'd0};
      vecs[1] = '{0, 32'd0,          32'd0,        0, 32'd14528};
      vecs[2] = '{0, 32'd0,          32'd0,        1, 32'd14528};
      vecs[3] = '{1, 32'd2816867292, 32'd526421,   0, 32'd0};
      vecs[4] = '{0, 32'd2816867292, 32'd0,        0, 32'd526421};
      vecs[5] = '{0, 32'd28,         32'd0,        0, pat(28)};
      vecs[6] = '{0, 32'd2816867292, 32'd0,        0, 32'd526421};
      vecs[7] = '{0, 32'd1001425,    32'd0,        0, pat(2001)};
      vecs[8] = '{1, 32'd1001425,    32'd25369366, 0, 32'd0};
      vecs[9] = '{0, 32'd1001425,    32'd0,        1, 32'd25369366};

      // Reset with a pending store request: it must be ignored.
      rst_n = 1'b0; req = 1'b1; we = 1'b1; addr = 32'd5; wdata = 32'hDEAD_BEEF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      @(posedge clk); #1 rst_n = 1'b1; req = 1'b0;

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].we) begin
            model_store(vecs[i].addr, vecs[i].wdata);
            do_store(vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d store", i));
         end else begin
            model_load(vecs[i].addr, eh, ed);
            do_load(vecs[i].addr, vecs[i].exp_hit, vecs[i].exp_data, $sformatf("vec%0d load", i));
         end
      end

      for (int i = 0; i < 300; i++) begin
         logic [31:0] a, d;
         a = ($urandom & 32'hFFFF_F000) | 32'(($urandom_range(0, 3) * LINES) + $urandom_range(0, 7));
         d = $urandom;
         if ($urandom_range(0, 2) == 0) begin
            model_store(a, d);
            do_store(a, d, $sformatf("rnd%0d store", i));
         end else begin
            model_load(a, eh, ed);
            do_load(a, eh, ed, $sformatf("rnd%0d load", i));
         end
      end

      // Reset in cycle 1 of a miss.
      req = 1'b1; we = 1'b0; addr = 32'd1234;
      @(posedge clk); #1 req = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("midreset ready", 32'(ready), 32'd1);
      check("midreset mem_write", 32'(mem_write), 32'd0);
      seen = rvalid ? 1 : 0;
      repeat (4) begin
         @(negedge clk);
         if (rvalid) seen++;
      end
      check("midreset rvalid suppressed", 32'(seen), 32'd0);
      check("midreset counts", {hit_count, miss_count}, 32'd0);
      model_reset();
      model_load(32'd1234, eh, ed);
      do_load(32'd1234, eh, ed, "post-reset load");
      check("post-reset load was a miss", 32'(eh), 32'd0);

      // Back-to-back hits until the hit counter saturates.
      errs = 0;
      req = 1'b1; we = 1'b0; addr = 32'd1234;
      for (int i = 0; i < 65537; i++) begin
         @(negedge clk);
         if (!(rvalid === 1'b1 && hit === 1'b1 && rdata === ed && ready === 1'b1)) errs++;
         if (i == 999)   check("hit_count after 1000", 32'(hit_count), 32'd1000);
         if (i == 65533) check("hit_count after 65534", 32'(hit_count), 32'd65534);
      end
      req = 1'b0;
      check("stream hit cycles", 32'(errs), 32'd0);
      check("hit_count saturated", 32'(hit_count), 32'd65535);
      check("miss_count unchanged", 32'(miss_count), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
